// File: rtl/phy_init_pkg.sv
// Register map, write table and state encoding shared by phy_init_sequencer.
// VERIFY_READBACK_EN adds the readback states and the per-entry compare masks.
package phy_init_pkg;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ANAR = 5'd4;

  localparam int BMSR_LINK_BIT = 2;
  localparam int BMSR_ANC_BIT  = 5;

  localparam int TBL_LEN = 3;
  localparam int IDX_W   = 2;

  localparam logic [15:0] TBL0_DATA = 16'h3100; // 100 Mb/s, AN enable, full duplex
  localparam logic [15:0] TBL1_DATA = 16'h0181; // advertise 100FD | 100HD, selector 1
  localparam logic [15:0] TBL2_DATA = 16'h3300; // entry 0 plus restart AN

  typedef enum logic [3:0] {
    ST_STARTUP    = 4'd0,
    ST_WR_ISSUE   = 4'd1,
    ST_WR_WAIT    = 4'd2,
`ifdef VERIFY_READBACK_EN
    ST_RB_ISSUE   = 4'd3,
    ST_RB_WAIT    = 4'd4,
`endif
    ST_POLL_ISSUE = 4'd5,
    ST_POLL_RD    = 4'd6,
    ST_POLL_WAIT  = 4'd7,
    ST_ERROR      = 4'd8
  } state_e;

  function automatic logic [4:0] tbl_regad(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd1:    return REG_ANAR;
      default: return REG_BMCR;
    endcase
  endfunction

  function automatic logic [15:0] tbl_data(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return TBL0_DATA;
      2'd1:    return TBL1_DATA;
      default: return TBL2_DATA;
    endcase
  endfunction

`ifdef VERIFY_READBACK_EN
  // Restart-AN (bit 9) self-clears, so it cannot be compared on readback.
  function automatic logic [15:0] tbl_mask(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd2:    return 16'hFDFF;
      default: return 16'hFFFF;
    endcase
  endfunction
`endif

endpackage

// File: rtl/phy_init_sequencer.sv
// MIIM bring-up sequencer for the ADIN1300: writes the config table, then polls BMSR for link.
// Define VERIFY_READBACK_EN to read back and compare every table write.
//
// state      | meaning
// STARTUP    | PHY power-up delay, STARTUP_DLY cycles
// WR_ISSUE   | wait for idle engine, strobe wren for table entry idx
// WR_WAIT    | wait for the write to finish (busy low)
// RB_ISSUE   | strobe rden for the register just written (readback build only)
// RB_WAIT    | wait rddata_valid, compare masked data (readback build only)
// POLL_ISSUE | wait for idle engine, strobe rden of BMSR
// POLL_RD    | wait rddata_valid, update link_up
// POLL_WAIT  | POLL_GAP cycles between polls; start restarts
// ERROR      | timeout or mismatch; no strobes until start/reset
module phy_init_sequencer
  import phy_init_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int unsigned STARTUP_DLY  = 20000,
  parameter int unsigned BUSY_TIMEOUT = 65535,
  parameter int unsigned POLL_GAP     = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  miim_phyad,
  output logic [4:0]  miim_regad,
  output logic [15:0] miim_wrdata,
  output logic        miim_wren,
  output logic        miim_rden,
  input  logic [15:0] miim_rddata,
  input  logic        miim_rddata_valid,
  input  logic        miim_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic        link_up
);

  localparam int unsigned DLY_MAX = (STARTUP_DLY > POLL_GAP) ? STARTUP_DLY : POLL_GAP;
  localparam int          DLY_W   = $clog2(DLY_MAX + 1);

  localparam logic [DLY_W-1:0] STARTUP_LAST = DLY_W'(STARTUP_DLY - 1);
  localparam logic [DLY_W-1:0] POLL_LAST    = DLY_W'(POLL_GAP - 1);
  localparam logic [15:0]      TO_LAST      = 16'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(TBL_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [15:0]      to_q, to_d;
  logic             skip_q, skip_d;
  logic [4:0]       regad_q, regad_d;
  logic [15:0]      wrdata_q, wrdata_d;
  logic             wren_q, wren_d;
  logic             rden_q, rden_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             link_q, link_d;

  logic waiting;
  logic entry_ok;
  logic fault;
  logic restart;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dly_d    = dly_q;
    to_d     = to_q;
    skip_d   = wren_q;
    regad_d  = regad_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    link_d   = link_q;
    waiting  = 1'b0;
    entry_ok = 1'b0;
    fault    = 1'b0;
    restart  = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        if (dly_q == STARTUP_LAST) begin
          dly_d   = '0;
          to_d    = '0;
          state_d = ST_WR_ISSUE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_WR_ISSUE: begin
        if (!miim_busy) begin
          regad_d  = tbl_regad(idx_q);
          wrdata_d = tbl_data(idx_q);
          wren_d   = 1'b1;
          to_d     = '0;
          state_d  = ST_WR_WAIT;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        // Busy is not trusted until the engine has had a cycle to see the strobe.
        if (!wren_q && !skip_q && !miim_busy) begin
`ifdef VERIFY_READBACK_EN
          to_d    = '0;
          state_d = ST_RB_ISSUE;
`else
          entry_ok = 1'b1;
`endif
        end else begin
          waiting = 1'b1;
        end
      end
`ifdef VERIFY_READBACK_EN
      ST_RB_ISSUE: begin
        if (!miim_busy) begin
          rden_d  = 1'b1;
          to_d    = '0;
          state_d = ST_RB_WAIT;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_RB_WAIT: begin
        if (miim_rddata_valid) begin
          if ((miim_rddata & tbl_mask(idx_q)) == (wrdata_q & tbl_mask(idx_q))) begin
            entry_ok = 1'b1;
          end else begin
            fault = 1'b1;
          end
        end else begin
          waiting = 1'b1;
        end
      end
`endif
      ST_POLL_ISSUE: begin
        if (!miim_busy) begin
          regad_d  = REG_BMSR;
          wrdata_d = '0;
          rden_d   = 1'b1;
          to_d     = '0;
          state_d  = ST_POLL_RD;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_POLL_RD: begin
        if (miim_rddata_valid) begin
          link_d  = miim_rddata[BMSR_LINK_BIT] & miim_rddata[BMSR_ANC_BIT];
          dly_d   = '0;
          state_d = ST_POLL_WAIT;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_POLL_WAIT: begin
        if (start) begin
          restart = 1'b1;
        end else if (dly_q == POLL_LAST) begin
          dly_d   = '0;
          to_d    = '0;
          state_d = ST_POLL_ISSUE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_ERROR: begin
        if (start) begin
          restart = 1'b1;
        end
      end
      default: begin
        fault = 1'b1;
      end
    endcase

    if (waiting) begin
      if (to_q == TO_LAST) begin
        fault = 1'b1;
      end else begin
        to_d = to_q + 16'd1;
      end
    end

    if (entry_ok) begin
      to_d = '0;
      if (idx_q == IDX_LAST) begin
        done_d  = 1'b1;
        state_d = ST_POLL_ISSUE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_WR_ISSUE;
      end
    end

    if (fault) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
      done_d  = 1'b0;
      link_d  = 1'b0;
    end

    if (restart) begin
      state_d = ST_STARTUP;
      idx_d   = '0;
      dly_d   = '0;
      to_d    = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      link_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_STARTUP;
      idx_q    <= '0;
      dly_q    <= '0;
      to_q     <= '0;
      skip_q   <= 1'b0;
      regad_q  <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      link_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dly_q    <= dly_d;
      to_q     <= to_d;
      skip_q   <= skip_d;
      regad_q  <= regad_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      done_q   <= done_d;
      err_q    <= err_d;
      link_q   <= link_d;
    end
  end

`ifndef VERIFY_READBACK_EN
  // Only the link and AN-complete bits matter without readback.
  logic unused_rddata;
  assign unused_rddata = ^{miim_rddata[15:6], miim_rddata[4:3], miim_rddata[1:0]};
`endif

  assign miim_phyad  = PHY_ADDR;
  assign miim_regad  = regad_q;
  assign miim_wrdata = wrdata_q;
  assign miim_wren   = wren_q;
  assign miim_rden   = rden_q;
  assign cfg_done    = done_q;
  assign cfg_error   = err_q;
  assign link_up     = link_q;

endmodule
